// File: rtl/vga_quadrant_scheduler.sv
// vga_quadrant_scheduler: 640x480 VGA timing with a 2x2 quadrant memory fetch pipeline.
// Define VGA_QUADRANT_BORDER_EN to enable the divider band and BORDER_COLOR insertion.
module vga_quadrant_scheduler #(
  parameter int H_SPLIT = 460,
  parameter int V_SPLIT = 272,
  parameter int BORDER_W = 6,
  parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [7:0]  mem_data,
  output logic [17:0] mem_addr,
  output logic        mem_rd,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        cross_area,
  output logic [7:0]  pixel_out,
  output logic        frame_done
);
  localparam logic [9:0] HB = 10'(H_SPLIT);
  localparam logic [9:0] HE = 10'(H_SPLIT + BORDER_W);
  localparam logic [9:0] VB = 10'(V_SPLIT);
  localparam logic [9:0] VE = 10'(V_SPLIT + BORDER_W);
  logic hs0, vs0, von0, band_raw, band0, qx, qy, rd0;
  logic hs1, vs1, von1, band1;
  logic [9:0] lx, ly;
  always_comb begin
    hs0 = !(h_count >= 10'd656 && h_count <= 10'd751);
    vs0 = !(v_count >= 10'd490 && v_count <= 10'd491);
    von0 = h_count < 10'd640 && v_count < 10'd480;
    band_raw = (h_count >= HB && h_count < HE) || (v_count >= VB && v_count < VE);
    qx = h_count >= HE;
    qy = v_count >= VE;
    lx = h_count - (qx ? HE : 10'd0);
    ly = v_count - (qy ? VE : 10'd0);
    // band pixels never fetch, whether or not the band is drawn
    rd0 = von0 && !band_raw && lx[9:8] == 2'b00 && ly[9:8] == 2'b00;
  end
`ifdef VGA_QUADRANT_BORDER_EN
  assign band0 = band_raw;
`else
  assign band0 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      h_count <= 10'd0;
      v_count <= 10'd0;
      mem_rd <= 1'b0;
      mem_addr <= 18'd0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      von1 <= 1'b0;
      band1 <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b0;
      cross_area <= 1'b0;
      pixel_out <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_en && h_count == 10'd799 && v_count == 10'd524;
      if (pix_en) begin
        h_count <= h_count == 10'd799 ? 10'd0 : h_count + 10'd1;
        v_count <= h_count != 10'd799 ? v_count : v_count == 10'd524 ? 10'd0 : v_count + 10'd1;
        mem_rd <= rd0;
        if (rd0) mem_addr <= {qy, qx, ly[7:0], lx[7:0]};
        hs1 <= hs0;
        vs1 <= vs0;
        von1 <= von0;
        band1 <= band0;
        hsync <= hs1;
        vsync <= vs1;
        video_on <= von1;
        cross_area <= band1;
        pixel_out <= !von1 ? 8'd0 : band1 ? BORDER_COLOR : mem_rd ? mem_data : 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_quadrant_scheduler.sv
// tb_vga_quadrant_scheduler: scoreboard bench comparing the pipeline against a pixel-position model.
module tb_vga_quadrant_scheduler;
  typedef struct packed {
    logic rd; logic [17:0] addr; logic [7:0] pix; logic hs, vs, von, cr;
  } exp_t;
  localparam int HS = 460, VS = 272, BW = 6;
`ifdef VGA_QUADRANT_BORDER_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic [7:0] mem_data, pixel_out;
  logic [17:0] mem_addr;
  logic [9:0] h_count, v_count;
  logic mem_rd, hsync, vsync, video_on, cross_area, frame_done;
  int errors = 0, checks = 0;
  int mh, mv, p1h, p1v, p2h, p2v, fd_cnt, hs_low, vs_low;
  logic [17:0] last_addr;
  exp_t q1[$], q2[$];
  exp_t last1, last2;
  const exp_t rst_e = '{rd: 1'b0, addr: 18'd0, pix: 8'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, cr: 1'b0};

  always #5 clk = ~clk;

  vga_quadrant_scheduler dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mem_data(mem_data), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .cross_area(cross_area), .pixel_out(pixel_out), .frame_done(frame_done)
  );

  function automatic logic [7:0] mem_fn(input logic [17:0] a);
    return a == 18'h03264 ? 8'hA5 : a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h3C;
  endfunction

  assign mem_data = mem_fn(mem_addr);

  function automatic exp_t model(input int h, input int v, input logic [17:0] la);
    exp_t e;
    bit braw, bnd, qx, qy, von;
    int lx, ly;
    braw = (h >= HS && h < HS + BW) || (v >= VS && v < VS + BW);
    bnd = braw && BEN;
    qx = h >= HS + BW;
    qy = v >= VS + BW;
    lx = qx ? h - HS - BW : h;
    ly = qy ? v - VS - BW : v;
    von = h < 640 && v < 480;
    e.rd = von && !braw && lx < 256 && ly < 256;
    e.addr = e.rd ? {qy, qx, ly[7:0], lx[7:0]} : la;
    e.pix = !von ? 8'd0 : bnd ? 8'hFF : e.rd ? mem_fn(e.addr) : 8'd0;
    e.hs = !(h >= 656 && h <= 751);
    e.vs = !(v == 490 || v == 491);
    e.von = von;
    e.cr = bnd;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, act, exp, mh, mv);
    end
  endtask

  task automatic check_outputs(input exp_t o1, input exp_t o2);
    check("mem_rd", 32'(mem_rd), 32'(o1.rd));
    check("mem_addr", 32'(mem_addr), 32'(o1.addr));
    check("pixel_out", 32'(pixel_out), 32'(o2.pix));
    check("hsync", 32'(hsync), 32'(o2.hs));
    check("vsync", 32'(vsync), 32'(o2.vs));
    check("video_on", 32'(video_on), 32'(o2.von));
    check("cross_area", 32'(cross_area), 32'(o2.cr));
  endtask

  task automatic tick();
    exp_t e;
    logic fd_exp;
    e = model(mh, mv, last_addr);
    last_addr = e.addr;
    q1.push_back(e);
    q2.push_back(e);
    fd_exp = mh == 799 && mv == 524;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    p2h = p1h; p2v = p1v; p1h = mh; p1v = mv;
    if (mh == 799) begin
      mh = 0;
      mv = mv == 524 ? 0 : mv + 1;
    end else mh++;
    last1 = q1.pop_front();
    if (q2.size() > 1) last2 = q2.pop_front();
    check_outputs(last1, last2);
    check("h_count", 32'(h_count), 32'(mh));
    check("v_count", 32'(v_count), 32'(mv));
    check("frame_done", 32'(frame_done), 32'(fd_exp));
    fd_cnt += int'(frame_done);
    hs_low += int'(!hsync);
    vs_low += int'(!vsync);
    if (p1h == 100 && p1v == 50) begin
      check("rd_100_50", 32'(mem_rd), 32'd1);
      check("addr_100_50", 32'(mem_addr), 32'h03264);
    end
    if (p2h == 100 && p2v == 50) begin
      check("pix_100_50", 32'(pixel_out), 32'hA5);
      check("von_100_50", 32'(video_on), 32'd1);
    end
    if (p1h == 462 && p1v == 10) check("rd_band", 32'(mem_rd), 32'd0);
    if (p2h == 462 && p2v == 10) begin
      check("pix_band", 32'(pixel_out), BEN ? 32'hFF : 32'h0);
      check("cross_band", 32'(cross_area), 32'(BEN));
    end
    if (p1h == 466 && p1v == 278) begin
      check("rd_466_278", 32'(mem_rd), 32'd1);
      check("addr_466_278", 32'(mem_addr), 32'h30000);
    end
    if (p1h == 722 && p1v == 278) check("rd_722_278", 32'(mem_rd), 32'd0);
    if (p2h == 722 && p2v == 278) check("pix_722_278", 32'(pixel_out), 32'd0);
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; p1h = -1; p1v = -1; p2h = -1; p2v = -1;
    last_addr = 18'd0;
    q1.delete();
    q2.delete();
    q2.push_back(rst_e);
    last1 = rst_e;
    last2 = rst_e;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_h"}, 32'(h_count), 32'd0);
    check({tag, "_v"}, 32'(v_count), 32'd0);
    check({tag, "_fd"}, 32'(frame_done), 32'd0);
    check_outputs(rst_e, rst_e);
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset_checks("rst");
    rst = 1'b0;
    while (!(mh == 300 && mv == 200)) tick();
    pix_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_outputs(last1, last2);
    check("frz_h", 32'(h_count), 32'(mh));
    check("frz_v", 32'(v_count), 32'(mv));
    check("frz_fd", 32'(frame_done), 32'd0);
    tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    reset_checks("midrst");
    fd_cnt = 0; hs_low = 0; vs_low = 0;
    repeat (420000) tick();
    check("frames", 32'(fd_cnt), 32'd1);
    check("hs_low", 32'(hs_low), 32'd50400);
    check("vs_low", 32'(vs_low), 32'd1600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_quadrant_scheduler.md
VGA_QUADRANT_SCHEDULER -- requirements
Module: vga_quadrant_scheduler

Interface
REQ-001 Parameters SHALL be: H_SPLIT, default 460, first column of the vertical divider band; V_SPLIT, default 272, first row of the horizontal divider band; BORDER_W, default 6, divider band width in pixels; BORDER_COLOR, default 8'hFF, divider band pixel value.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-tick clock enable.
- mem_data  in  8  shared frame memory read data.
- mem_addr  out  18  shared memory read address, {quadrant, ly[7:0], lx[7:0]}.
- mem_rd  out  1  memory read strobe.
- h_count  out  10  stage-0 column.
- v_count  out  10  stage-0 row.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  active-area flag.
- cross_area  out  1  divider-band flag.
- pixel_out  out  8  pixel value.
- frame_done  out  1  end-of-frame pulse.
- The clock is one domain only; reset is synchronous and active-high.

Function
REQ-003 All state SHALL advance only on rising clk edges with pix_en=1; with pix_en=0, every register holds.
REQ-004 h_count SHALL count 0..799 and wrap to 0; v_count SHALL increment when h_count wraps, count 0..524, and wrap to 0.
REQ-005 Stage-0 hsync SHALL be 0 for h_count 656..751; stage-0 vsync SHALL be 0 for v_count 490..491; stage-0 video_on SHALL be h_count<640 and v_count<480.
REQ-006 Band SHALL be h_count in [H_SPLIT, H_SPLIT+BORDER_W-1] or v_count in [V_SPLIT, V_SPLIT+BORDER_W-1], inclusive.
REQ-007 Quadrant SHALL be {v_count>=V_SPLIT+BORDER_W, h_count>=H_SPLIT+BORDER_W}, giving 0=TL, 1=TR, 2=BL, 3=BR.
REQ-008 Local coordinates SHALL be relative to the quadrant origin: origin x is 0 or H_SPLIT+BORDER_W; origin y is 0 or V_SPLIT+BORDER_W.
REQ-009 Local x or local y >= 256 SHALL mean outside the window.
REQ-010 Stage 1 (registered) SHALL assert mem_rd=1 and present mem_addr={quadrant, ly[7:0], lx[7:0]} iff stage-0 video_on=1, band=0 and the pixel is inside the window; otherwise mem_rd=0 and mem_addr holds its last value.
REQ-011 Memory SHALL present mem_data one pix_en tick after mem_rd.
REQ-012 Stage 2 pixel_out SHALL select, in priority order:
- 0 if video_on=0;
- BORDER_COLOR if band=1;
- mem_data if a read was issued;
- 0 otherwise.
REQ-013 hsync, vsync, video_on and cross_area outputs SHALL be the stage-0 values delayed 2 pix_en ticks, aligned with pixel_out.
REQ-014 h_count and v_count outputs SHALL be undelayed stage 0.
REQ-015 frame_done SHALL pulse for exactly one clk cycle on the pix_en tick where h_count=799 and v_count=524 wrap to 0,0.
REQ-016 Sync and band flags SHALL be generated in blanking identically to active area; mem_rd SHALL never assert in blanking.

Reset
REQ-017 With rst=1 at a clk edge, regardless of pix_en, the block SHALL set:
- h_count=0, v_count=0;
- all pipeline stages cleared: hsync=1, vsync=1, video_on=0, cross_area=0, mem_rd=0, mem_addr=0, pixel_out=0;
- frame_done=0.
REQ-018 Reset mid-frame SHALL restart timing at 0,0 on the first pix_en tick after rst falls, with no stale pipeline data emitted.

Configuration
REQ-019 Macro VGA_QUADRANT_BORDER_EN SHALL select the divider-band behaviour:
- Defined: band detection and BORDER_COLOR insertion operate as specified.
- Undefined: cross_area is tied 0; band pixels follow REQ-012 as non-band, are outside every window, produce no mem_rd, and output 0. Quadrant origins are unchanged.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset, then 420000 pix_en ticks -> exactly one frame_done per 420000 ticks; hsync low 96 ticks per line; vsync low 1600 ticks per frame.
- Stage-0 h=100, v=50 -> mem_rd=1 with mem_addr=18'h03264; memory returns 8'hA5 -> pixel_out=8'hA5 two ticks later with video_on=1.
- Stage-0 h=462, v=10, macro defined -> no mem_rd; pixel_out=8'hFF; cross_area=1 on the same output tick.
- Stage-0 h=466, v=278 -> mem_addr={2'b11,8'h00,8'h00}; h=722, v=278 -> outside window: mem_rd=0, pixel_out=0.
- pix_en held 0 for 10 clk mid-line -> all outputs frozen; rst pulsed at h=300, v=200 -> next tick shows h=0, v=0, hsync=1, pixel_out=0.
- Macro undefined, h=462, v=10 -> cross_area=0, pixel_out=0, mem_rd=0.
